lane_scatter: RTL and testbench
===============================

# lane_scatter

Stream-to-lanes scatter for the MPI operation datapath and the inverse of the n-lane reduction blocks. It accepts a serial stream of 16-bit words and distributes them into an n-lane, 16·n-bit vector according to a lane-select mask. Lanes that are not selected are filled with the AND identity, 16'hFFFF. The output vector uses the same lane packing and valid/ready/start/last framing that the reduction blocks consume on their input.

## Interface
- n, 4: number of 16-bit output lanes (n ≥ 2).
- aclk  in  1  clock; all state changes on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- outputSelect  in  n  lane mask; bit k enables lane k. All-zero is treated as all-ones.
- idata  in  16  input word.
- ivalid  in  1  idata valid.
- iready  out  1  block can accept a word (registered).
- istart  in  1  first word of a packet.
- ilast  in  1  last word of a packet.
- odata  out  16·n  assembled vector; lane k occupies odata[16(k+1)-1 -: 16].
- ovalid  out  1  odata valid.
- oready  in  1  downstream accepts.
- ostart  out  1  first vector of a packet.
- olast  out  1  last vector of a packet.
- oerror  out  1  sticky protocol-error flag.

## Operation
- An input word is accepted when ivalid && iready. An output vector is consumed when ovalid && oready.
- **Group fill:**
  - A group is one output vector.
  - The mask is sampled from outputSelect on the first accepted word of a group and latched for the remainder of the group.
  - Accepted words fill the selected lanes in descending order, lane n-1 first. Deselected lanes are skipped.
- **Group complete:** a group completes on acceptance of either:
  - the word that fills the lowest selected lane, or
  - a word with ilast=1, whichever comes first.
  On completion, every selected lane that is still unfilled and every deselected lane hold 16'hFFFF.
- **Framing:**
  - A group containing a word accepted with istart=1 gets ostart=1.
  - A group completed by ilast gets olast=1.
  - A single word with istart=1 and ilast=1 gives one vector with both flags set.
- **Storage:** two registers.
  - Assembly register (A): collects the group in progress.
  - Output register (O): drives odata, ovalid, ostart and olast.
- **Transfer on completion:**
  - If O is empty, or O is being consumed in the same cycle, the completed group loads into O at that edge.
  - Otherwise the group stays in A with pend=1.
- **While pend=1:**
  - iready=0.
  - In the cycle where O is consumed, O loads A and pend clears. iready returns to 1 on the following edge.
- **istart while A is partially filled (protocol error):**
  - oerror is set and stays set.
  - The partial group is discarded and nothing is emitted for it.
  - The istart word begins a new group, using the mask as sampled in that cycle.
- An accepted word with istart=0 that arrives while no packet is open is treated as a normal word, with no error.

## Timing
- **Reset (areset=1, immediate):**
  - iready=0, ovalid=0, ostart=0, olast=0, oerror=0, odata=0.
  - A cleared, pend=0, lane pointer at n-1.
  - Any group in progress is lost.
- iready rises on the first clock edge after areset deasserts.
- **Latency:** the completing word is accepted at edge k; ovalid is 1 after edge k, provided O was free or draining.
- **Throughput:** one word per cycle with no stall while oready=1. Back-to-back groups produce back-to-back vectors.
- **O contents:** ovalid, odata, ostart and olast are held stable while ovalid && !oready. ovalid drops after the consuming edge unless a new group loads at that same edge.
- **Worst-case buffering:** one vector in O plus one complete group in A. iready deasserts on the edge at which the second group completes while O is stalled.
- When oready is held low, no words are lost and vectors are not reordered.

## Test plan
- **Full mask:** n=4, mask 4'b1111, oready=1. Words 1111, 2222, 3333, 4444, with istart on the first and ilast on the fourth. Required: one vector odata=1111_2222_3333_4444, ostart=1, olast=1, ovalid one cycle after the 4th acceptance.
- **Sparse mask:** mask 4'b1010, words AAAA then BBBB. Required: odata=AAAA_FFFF_BBBB_FFFF, one vector. Also mask 4'b0000 with 4 words: behaves as mask 4'b1111.
- **Early ilast:** mask 4'b1111, words 0001, 0002 with ilast on the second. Required: odata=0001_0002_FFFF_FFFF, olast=1.
- **Backpressure:** oready=0, 8 words streamed continuously (two full groups). Required: iready=0 after the 8th acceptance. Raise oready: the vectors appear in order on consecutive cycles, then iready=1.
- **Mid-group istart:** mask 4'b1111, words 1234, 5678, then 9ABC with istart, then three more words. Required: oerror=1 and stays set; exactly one vector, 9ABC_..., with ostart=1.
- **Reset mid-operation:** pulse areset after 2 words of a group, and once with ovalid=1 and oready=0. Required: all outputs 0 immediately; no stale vector after release; the next group assembles from lane n-1.

Source files
------------

// File: rtl/lane_scatter_if.sv
// lane_scatter_if
// Valid/ready stream bundle with packet framing, parameterised by data width.
// The same bundle carries the serial word stream into lane_scatter and the
// assembled lane vector out of it.
//   data  : payload (W bits)
//   valid : payload valid, driven by the master
//   ready : sink can accept, driven by the slave
//   start : first beat of a packet
//   last  : last beat of a packet
interface lane_scatter_if #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         start;
    logic         last;

    modport master (output data, output valid, output start, output last, input ready);
    modport slave  (input data, input valid, input start, input last, output ready);
endinterface

// File: rtl/lane_scatter.sv
// lane_scatter
// Scatters a serial stream of 16-bit words into an N-lane vector of 16*N bits.
// Words fill the lanes enabled by outputSelect from lane N-1 downwards; lanes
// that are deselected or left unfilled by an early ilast read 16'hFFFF (the
// AND identity), so the vector can feed an AND reduction directly.
// Ports:
//   aclk, areset  : clock, asynchronous active-high reset
//   outputSelect  : lane mask, sampled on the first word of each group
//                   (all-zero behaves as all-ones)
//   in_s          : word stream in (data = idata, ready = iready, registered)
//   out_s         : vector stream out (data = odata, lane k at [16k+15:16k])
//   oerror        : sticky flag, set by istart arriving mid-group
module lane_scatter #(
    parameter int N = 4
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [N-1:0]  outputSelect,
    lane_scatter_if.slave  in_s,
    lane_scatter_if.master out_s,
    output logic          oerror
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    // Assembly register state
    logic [N-1:0]    a_mask_reg;
    logic [LW-1:0]   lane_ptr_reg;
    logic            a_active_reg;   // group partially filled
    logic            a_start_reg;
    logic            a_last_reg;
    logic            pend_reg;       // A holds a complete group waiting for O
    logic            pend_next;

    // Output register state
    logic [16*N-1:0] o_data_reg;
    logic            o_valid_reg;
    logic            o_start_reg;
    logic            o_last_reg;

    logic            iready_reg;
    logic            oerror_reg;

    // Datapath
    logic [N-1:0]    sel_eff;
    logic [N-1:0]    cur_mask;
    logic [LW-1:0]   top_lane;
    logic [LW-1:0]   cur_lane;
    logic [LW-1:0]   nxt_lane;
    logic            nxt_found;
    logic            accept;
    logic            new_group;
    logic            complete;
    logic            cur_start;
    logic            o_consume;
    logic            o_free;
    logic [16*N-1:0] assembled;      // A contents including this cycle's word
    logic [16*N-1:0] a_packed;       // A contents as registered

    assign sel_eff   = (outputSelect == '0) ? '1 : outputSelect;
    assign accept    = in_s.valid && iready_reg;
    // An istart word always opens a fresh group, even over a partial one.
    assign new_group = !a_active_reg || in_s.start;
    assign cur_mask  = new_group ? sel_eff : a_mask_reg;
    assign cur_lane  = new_group ? top_lane : lane_ptr_reg;
    assign cur_start = new_group ? in_s.start : a_start_reg;
    assign complete  = accept && (in_s.last || !nxt_found);
    assign o_consume = o_valid_reg && out_s.ready;
    assign o_free    = !o_valid_reg || out_s.ready;

    // Highest enabled lane: where the first word of a group lands.
    always_comb begin
        top_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_eff[i]) top_lane = LW'(i);
        end
    end

    // Next enabled lane below the one being written; none means the group ends.
    always_comb begin
        nxt_lane  = '0;
        nxt_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_mask[i] && (LW'(i) < cur_lane)) begin
                nxt_lane  = LW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        pend_next = pend_reg;
        if (complete && !o_free)
            pend_next = 1'b1;
        else if (pend_reg && o_consume)
            pend_next = 1'b0;
    end

    // Per-lane assembly storage. A new group presets every lane to FFFF, so
    // anything not written before completion already holds the identity.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [15:0] lane_reg;
            logic [15:0] lane_next;

            always_comb begin
                lane_next = lane_reg;
                if (accept) begin
                    if (cur_lane == LW'(gi))
                        lane_next = in_s.data;
                    else if (new_group)
                        lane_next = 16'hFFFF;
                end
            end

            always_ff @(posedge aclk or posedge areset) begin
                if (areset)
                    lane_reg <= '0;
                else if (accept)
                    lane_reg <= lane_next;
            end

            assign assembled[16*gi+15 -: 16] = lane_next;
            assign a_packed[16*gi+15 -: 16]  = lane_reg;
        end
    endgenerate

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            a_mask_reg   <= '0;
            lane_ptr_reg <= LW'(N - 1);
            a_active_reg <= 1'b0;
            a_start_reg  <= 1'b0;
            a_last_reg   <= 1'b0;
            pend_reg     <= 1'b0;
            o_data_reg   <= '0;
            o_valid_reg  <= 1'b0;
            o_start_reg  <= 1'b0;
            o_last_reg   <= 1'b0;
            iready_reg   <= 1'b0;
            oerror_reg   <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            // Hold iready low for one extra edge after the pending group moves to O.
            iready_reg <= !pend_next && !pend_reg;

            if (accept && a_active_reg && in_s.start)
                oerror_reg <= 1'b1;

            if (accept) begin
                a_mask_reg   <= cur_mask;
                lane_ptr_reg <= complete ? LW'(N - 1) : nxt_lane;
                a_active_reg <= !complete;
                a_start_reg  <= cur_start;
                a_last_reg   <= in_s.last;
            end

            if (complete && o_free) begin
                o_data_reg  <= assembled;
                o_valid_reg <= 1'b1;
                o_start_reg <= cur_start;
                o_last_reg  <= in_s.last;
            end else if (pend_reg && o_consume) begin
                o_data_reg  <= a_packed;
                o_valid_reg <= 1'b1;
                o_start_reg <= a_start_reg;
                o_last_reg  <= a_last_reg;
            end else if (o_consume) begin
                o_valid_reg <= 1'b0;
                o_start_reg <= 1'b0;
                o_last_reg  <= 1'b0;
            end
        end
    end

    assign in_s.ready  = iready_reg;
    assign out_s.data  = o_data_reg;
    assign out_s.valid = o_valid_reg;
    assign out_s.start = o_start_reg;
    assign out_s.last  = o_last_reg;
    assign oerror      = oerror_reg;
endmodule

// File: tb/tb_lane_scatter.sv
module tb_lane_scatter;
    localparam int N = 4;

    logic         aclk;
    logic         areset;
    logic [N-1:0] output_select;
    logic         oerror;

    lane_scatter_if #(.W(16))     in_if ();
    lane_scatter_if #(.W(16 * N)) out_if ();

    lane_scatter #(.N(N)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .outputSelect (output_select),
        .in_s         (in_if),
        .out_s        (out_if),
        .oerror       (oerror)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Vectors consumed by the sink: {data, start, last}
    logic [16*N+1:0] cap_q[$];

    always @(negedge aclk) begin
        if (!areset && out_if.valid && out_if.ready)
            cap_q.push_back({out_if.data, out_if.start, out_if.last});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Present one word and return just after the edge that accepts it.
    task automatic send(input logic [15:0] d, input logic s, input logic l);
        int n;
        in_if.data  = d;
        in_if.start = s;
        in_if.last  = l;
        in_if.valid = 1'b1;
        n = 0;
        while (!in_if.ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_if.ready) check("send_timeout", 64'(in_if.ready), 64'd1);
        tick();
        in_if.valid = 1'b0;
        in_if.start = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iready"}, 64'(in_if.ready), 64'd0);
        check({tag, "_ovalid"}, 64'(out_if.valid), 64'd0);
        check({tag, "_oflags"}, 64'({out_if.start, out_if.last, oerror}), 64'd0);
        check({tag, "_odata"},  out_if.data, 64'd0);
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        #1;
        check_reset_outputs("rst_pulse");
        tick();
        areset = 1'b0;
        tick();
        check("rst_release_iready", 64'(in_if.ready), 64'd1);
    endtask

    initial begin
        areset        = 1'b1;
        output_select = 4'b1111;
        in_if.data    = '0;
        in_if.valid   = 1'b0;
        in_if.start   = 1'b0;
        in_if.last    = 1'b0;
        out_if.ready  = 1'b1;

        // Reset state
        #2;
        check_reset_outputs("por");
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("por_iready_up", 64'(in_if.ready), 64'd1);

        // Full mask, one packet of four words
        cap_q.delete();
        send(16'h1111, 1'b1, 1'b0);
        check("full_not_yet", 64'(out_if.valid), 64'd0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0);
        send(16'h4444, 1'b0, 1'b1);
        check("full_ovalid", 64'(out_if.valid), 64'd1);
        check("full_odata",  out_if.data, 64'h1111_2222_3333_4444);
        check("full_flags",  64'({out_if.start, out_if.last}), 64'b11);
        tick();
        check("full_drop",   64'(out_if.valid), 64'd0);
        check("full_count",  64'(cap_q.size()), 64'd1);

        // Sparse mask 1010
        cap_q.delete();
        output_select = 4'b1010;
        send(16'hAAAA, 1'b1, 1'b0);
        send(16'hBBBB, 1'b0, 1'b0);
        check("sparse_odata", out_if.data, 64'hAAAA_FFFF_BBBB_FFFF);
        check("sparse_flags", 64'({out_if.valid, out_if.start, out_if.last}), 64'b110);
        tick();
        check("sparse_count", 64'(cap_q.size()), 64'd1);

        // All-zero mask acts as all-ones
        cap_q.delete();
        output_select = 4'b0000;
        send(16'h0A01, 1'b1, 1'b0);
        send(16'h0A02, 1'b0, 1'b0);
        send(16'h0A03, 1'b0, 1'b0);
        check("zmask_not_yet", 64'(out_if.valid), 64'd0);
        send(16'h0A04, 1'b0, 1'b1);
        check("zmask_odata", out_if.data, 64'h0A01_0A02_0A03_0A04);
        tick();
        check("zmask_count", 64'(cap_q.size()), 64'd1);

        // Early ilast pads the remaining lanes
        cap_q.delete();
        output_select = 4'b1111;
        send(16'h0001, 1'b1, 1'b0);
        send(16'h0002, 1'b0, 1'b1);
        check("early_odata", out_if.data, 64'h0001_0002_FFFF_FFFF);
        check("early_flags", 64'({out_if.valid, out_if.start, out_if.last}), 64'b111);
        tick();
        check("early_count", 64'(cap_q.size()), 64'd1);

        // Backpressure: two full groups while the sink is stalled
        cap_q.delete();
        out_if.ready = 1'b0;
        send(16'h0101, 1'b1, 1'b0);
        send(16'h0102, 1'b0, 1'b0);
        send(16'h0103, 1'b0, 1'b0);
        send(16'h0104, 1'b0, 1'b1);
        check("bp_iready_mid", 64'(in_if.ready), 64'd1);
        send(16'h0201, 1'b1, 1'b0);
        send(16'h0202, 1'b0, 1'b0);
        send(16'h0203, 1'b0, 1'b0);
        send(16'h0204, 1'b0, 1'b1);
        check("bp_iready_low", 64'(in_if.ready), 64'd0);
        tick();
        tick();
        check("bp_hold_odata",  out_if.data, 64'h0101_0102_0103_0104);
        check("bp_hold_iready", 64'(in_if.ready), 64'd0);
        out_if.ready = 1'b1;
        tick();
        check("bp_second_valid", 64'(out_if.valid), 64'd1);
        check("bp_second_odata", out_if.data, 64'h0201_0202_0203_0204);
        tick();
        check("bp_drain_valid",  64'(out_if.valid), 64'd0);
        check("bp_iready_back",  64'(in_if.ready), 64'd1);
        check("bp_count", 64'(cap_q.size()), 64'd2);
        if (cap_q.size() == 2) begin
            check("bp_order0", 64'(cap_q[0][16*N+1:2]), 64'h0101_0102_0103_0104);
            check("bp_order1", 64'(cap_q[1][16*N+1:2]), 64'h0201_0202_0203_0204);
        end
        check("bp_no_error", 64'(oerror), 64'd0);

        // istart in the middle of a group
        cap_q.delete();
        send(16'h1234, 1'b1, 1'b0);
        send(16'h5678, 1'b0, 1'b0);
        send(16'h9ABC, 1'b1, 1'b0);
        check("mid_oerror", 64'(oerror), 64'd1);
        check("mid_no_vec", 64'(out_if.valid), 64'd0);
        send(16'hDEF0, 1'b0, 1'b0);
        send(16'h1357, 1'b0, 1'b0);
        send(16'h2468, 1'b0, 1'b1);
        check("mid_odata", out_if.data, 64'h9ABC_DEF0_1357_2468);
        check("mid_flags", 64'({out_if.valid, out_if.start, out_if.last}), 64'b111);
        tick();
        tick();
        check("mid_oerror_sticky", 64'(oerror), 64'd1);
        check("mid_count", 64'(cap_q.size()), 64'd1);

        // Reset after two words of a group
        send(16'hEE01, 1'b1, 1'b0);
        send(16'hEE02, 1'b0, 1'b0);
        pulse_reset();
        cap_q.delete();
        send(16'h1001, 1'b0, 1'b0);
        send(16'h1002, 1'b0, 1'b0);
        send(16'h1003, 1'b0, 1'b0);
        check("rst1_not_yet", 64'(out_if.valid), 64'd0);
        send(16'h1004, 1'b0, 1'b1);
        check("rst1_odata", out_if.data, 64'h1001_1002_1003_1004);
        tick();
        check("rst1_count", 64'(cap_q.size()), 64'd1);

        // Reset while a vector is stalled in O
        out_if.ready = 1'b0;
        send(16'h2001, 1'b1, 1'b0);
        send(16'h2002, 1'b0, 1'b0);
        send(16'h2003, 1'b0, 1'b0);
        send(16'h2004, 1'b0, 1'b1);
        check("rst2_stalled", 64'(out_if.valid), 64'd1);
        pulse_reset();
        cap_q.delete();
        out_if.ready = 1'b1;
        tick();
        tick();
        check("rst2_no_stale", 64'(cap_q.size()), 64'd0);
        check("rst2_ovalid",   64'(out_if.valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
